// File: rtl/mem_suspend_ctrl.sv
// Data-memory access sequencer: issues da_req from EX, stalls the pipeline until
// da_ack, pulses suspend_finish for the forwarding cycle, and flushes on EX jumps.
module mem_suspend_ctrl #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ex_valid,
  input  logic             ex_sel_ram,
  input  logic             ex_store,
  input  logic             ex_jump,
  input  logic             da_ack,
  output logic             da_req,
  output logic             suspend_finish,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] susp_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              mem_op;
  logic              stall;
  logic              flush;

  assign mem_op   = ex_valid & (ex_sel_ram | ex_store);
  assign wait_inc = wait_cnt + WAIT_W'(1);

  // Gated by reset so the request and stalls drop in the very cycle reset asserts,
  // even though the EX stage may still be presenting a memory op.
  assign stall = ~cpu_rst & (((state == S_IDLE) & mem_op) | (state == S_WAIT));
  assign flush = ~cpu_rst & ex_valid & ex_jump & ~stall;

  assign da_req       = stall;
  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign stall_id_ex  = stall;
  assign stall_ex_mem = stall;
  assign flush_if_id  = flush;
  assign flush_id_ex  = flush;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      suspend_finish <= 1'b0;
      mem_timeout    <= 1'b0;
      susp_cnt       <= '0;
    end else begin
      suspend_finish <= 1'b0;
      if (stall) begin
        susp_cnt <= susp_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (da_ack) begin
            state          <= S_DONE;
            suspend_finish <= 1'b1;
          end else if (wait_cnt != WAIT_LAST) begin
            // Saturates at the limit; the flag is sticky so no need to keep counting.
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_LAST) begin
              mem_timeout <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_suspend_ctrl.sv
// Directed bench for mem_suspend_ctrl: per-cycle vector table plus hand-written
// reset, timeout and counter-wrap sequences.
module tb_mem_suspend_ctrl;

  logic       clk;
  logic       rst;
  logic       ex_valid, ex_sel_ram, ex_store, ex_jump, da_ack;
  logic       da_req, suspend_finish;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       flush_if_id, flush_id_ex, mem_timeout;
  logic [3:0] susp_cnt;

  int checks = 0;
  int errors = 0;

  mem_suspend_ctrl #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .cpu_clk       (clk),
    .cpu_rst       (rst),
    .ex_valid      (ex_valid),
    .ex_sel_ram    (ex_sel_ram),
    .ex_store      (ex_store),
    .ex_jump       (ex_jump),
    .da_ack        (da_ack),
    .da_req        (da_req),
    .suspend_finish(suspend_finish),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .stall_id_ex   (stall_id_ex),
    .stall_ex_mem  (stall_ex_mem),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .mem_timeout   (mem_timeout),
    .susp_cnt      (susp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, ld, st, j, ack;
    logic       req, stl, fin, fl, tmo;
    logic [3:0] cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic v, ld, st, j, ack,
                              input logic req, stl, fin, fl, tmo, input logic [3:0] cnt);
    vec_t r;
    r.v = v; r.ld = ld; r.st = st; r.j = j; r.ack = ack;
    r.req = req; r.stl = stl; r.fin = fin; r.fl = fl; r.tmo = tmo; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input logic req, stl, fin, fl, tmo,
                         input logic [3:0] cnt);
    chk({name, ".da_req"}, idx, {31'd0, da_req}, {31'd0, req});
    chk({name, ".stall"}, idx, {28'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem},
        {28'd0, {4{stl}}});
    chk({name, ".suspend_finish"}, idx, {31'd0, suspend_finish}, {31'd0, fin});
    chk({name, ".flush"}, idx, {30'd0, flush_if_id, flush_id_ex}, {30'd0, {2{fl}}});
    chk({name, ".mem_timeout"}, idx, {31'd0, mem_timeout}, {31'd0, tmo});
    chk({name, ".susp_cnt"}, idx, {28'd0, susp_cnt}, {28'd0, cnt});
    $display("%s[%0d]: req=%0b stall=%0b fin=%0b flush=%0b tmo=%0b cnt=%0d",
             name, idx, da_req, stall_pc, suspend_finish, flush_if_id, mem_timeout, susp_cnt);
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic cyc(input logic v, ld, st, j, ack);
    @(negedge clk);
    ex_valid = v; ex_sel_ram = ld; ex_store = st; ex_jump = j; da_ack = ack;
    #1;
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_all(name, 0, 0, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    ex_valid = 0; ex_sel_ram = 0; ex_store = 0; ex_jump = 0; da_ack = 0;
    rst = 1'b0;
  endtask

  initial begin
    //                v  ld st j  ack  req stl fin fl tmo cnt
    vecs[0]  = mk(1, 1, 0, 0, 0,   1,  1,  0,  0, 0,  4'd0);
    vecs[1]  = mk(1, 1, 0, 0, 0,   1,  1,  0,  0, 0,  4'd1);
    vecs[2]  = mk(1, 1, 0, 0, 0,   1,  1,  0,  0, 0,  4'd2);
    vecs[3]  = mk(1, 1, 0, 0, 1,   1,  1,  0,  0, 0,  4'd3);
    vecs[4]  = mk(1, 1, 0, 0, 0,   0,  0,  1,  0, 0,  4'd4);
    vecs[5]  = mk(0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  4'd4);
    vecs[6]  = mk(1, 1, 0, 0, 0,   1,  1,  0,  0, 0,  4'd4);
    vecs[7]  = mk(1, 1, 0, 0, 1,   1,  1,  0,  0, 0,  4'd5);
    vecs[8]  = mk(1, 1, 0, 0, 0,   0,  0,  1,  0, 0,  4'd6);
    vecs[9]  = mk(1, 0, 1, 0, 0,   1,  1,  0,  0, 0,  4'd6);
    vecs[10] = mk(1, 0, 1, 0, 1,   1,  1,  0,  0, 0,  4'd7);
    vecs[11] = mk(1, 0, 1, 0, 0,   0,  0,  1,  0, 0,  4'd8);
    vecs[12] = mk(1, 0, 0, 1, 0,   0,  0,  0,  1, 0,  4'd8);
    vecs[13] = mk(0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  4'd8);
    vecs[14] = mk(1, 1, 0, 1, 0,   1,  1,  0,  0, 0,  4'd8);
    vecs[15] = mk(1, 1, 0, 1, 0,   1,  1,  0,  0, 0,  4'd9);
    vecs[16] = mk(1, 1, 0, 1, 1,   1,  1,  0,  0, 0,  4'd10);
    vecs[17] = mk(1, 1, 0, 0, 0,   0,  0,  1,  0, 0,  4'd11);
    vecs[18] = mk(0, 0, 0, 0, 1,   0,  0,  0,  0, 0,  4'd11);
    vecs[19] = mk(0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  4'd11);
    vecs[20] = mk(0, 1, 1, 1, 0,   0,  0,  0,  0, 0,  4'd11);

    // Reset held with a load presented: outputs must still be all zero.
    rst = 1'b1;
    ex_valid = 1; ex_sel_ram = 1; ex_store = 0; ex_jump = 0; da_ack = 0;
    #2 chk_all("reset", 0, 0, 0, 0, 0, 0, 4'd0);
    ex_valid = 0; ex_sel_ram = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].j, vecs[i].ack);
      chk_all("vec", i, vecs[i].req, vecs[i].stl, vecs[i].fin, vecs[i].fl, vecs[i].tmo, vecs[i].cnt);
    end

    // Reset asserted asynchronously while an access is outstanding.
    cyc(1, 1, 0, 0, 0);
    chk_all("midrst_req", 0, 1, 1, 0, 0, 0, 4'd11);
    cyc(1, 1, 0, 0, 0);
    chk_all("midrst_wait", 0, 1, 1, 0, 0, 0, 4'd12);
    #2 rst = 1'b1;
    #1 chk_all("midrst_async", 0, 0, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    ex_valid = 0; ex_sel_ram = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk_all("postrst_idle", i, 0, 0, 0, 0, 0, 4'd0);
    end

    // Watchdog: no ack for 7 WAIT cycles sets the sticky flag; a late ack still completes.
    cyc(1, 1, 0, 0, 0);
    chk_all("tmo_req", 0, 1, 1, 0, 0, 0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 1, 0, 0, 0);
      chk_all("tmo_wait", k, 1, 1, 0, 0, 0, 4'(k));
    end
    cyc(1, 1, 0, 0, 0);
    chk_all("tmo_set", 8, 1, 1, 0, 0, 1, 4'd8);
    cyc(1, 1, 0, 0, 1);
    chk_all("tmo_ack", 9, 1, 1, 0, 0, 1, 4'd9);
    cyc(1, 1, 0, 0, 0);
    chk_all("tmo_done", 10, 0, 0, 1, 0, 1, 4'd10);
    cyc(0, 0, 0, 0, 0);
    chk_all("tmo_sticky", 11, 0, 0, 0, 0, 1, 4'd10);

    // Counter wrap: 1 IDLE + 16 WAIT stalled cycles = 17 -> 1 modulo 16.
    pulse_reset("wrap_rst");
    cyc(1, 1, 0, 0, 0);
    chk("wrap_cnt", 0, {28'd0, susp_cnt}, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      cyc(1, 1, 0, 0, 0);
      chk("wrap_cnt", k, {28'd0, susp_cnt}, 32'(k));
    end
    cyc(1, 0, 1, 0, 1);
    chk("wrap_cnt", 16, {28'd0, susp_cnt}, 32'd0);
    chk("wrap_req", 16, {31'd0, da_req}, 32'd1);
    cyc(1, 0, 1, 0, 0);
    chk("wrap_cnt", 17, {28'd0, susp_cnt}, 32'd1);
    chk("wrap_fin", 17, {31'd0, suspend_finish}, 32'd1);
    chk("wrap_stall", 17, {31'd0, stall_pc}, 32'd0);
    $display("wrap: susp_cnt=%0d after 17 stalled cycles", susp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_suspend_ctrl.md
Name: mem_suspend_ctrl

Overview:
- Pipeline sequencer for the 5-stage LA32R core. It issues data-memory accesses from the EX stage and suspends the pipeline while each access is outstanding.
- When the data returns it pulses suspend_finish for one cycle. That cycle is when the ID-stage forwarding unit may forward mem_wd for a Load-Use hazard.
- It also generates the flush signals for taken branches and jumps resolved in EX.
- It keeps a timeout watchdog and a suspended-cycle counter.

Parameters:
- TIMEOUT_CYC, 256: WAIT cycles without da_ack before mem_timeout is set.
- CNT_W, 32: width of the suspend cycle counter.

Ports:
- cpu_clk  in  1  core clock; all state updates on rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_sel_ram  in  1  EX instruction is a Load.
- ex_store  in  1  EX instruction is a Store.
- ex_jump  in  1  EX instruction is a taken branch or jump.
- da_ack  in  1  data-memory response pulse; read data is valid on mem_wd this cycle.
- da_req  out  1  data-memory request; held high until da_ack.
- suspend_finish  out  1  one-cycle pulse: the suspension has ended and returned data is valid.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID register.
- stall_id_ex  out  1  hold the ID/EX register.
- stall_ex_mem  out  1  hold the EX/MEM register.
- flush_if_id  out  1  clear the IF/ID register to a bubble.
- flush_id_ex  out  1  clear the ID/EX register to a bubble.
- mem_timeout  out  1  sticky watchdog flag.
- susp_cnt  out  CNT_W  count of suspended cycles; wraps modulo 2^CNT_W.

Behaviour:
- Access detection: mem_op = ex_valid & (ex_sel_ram | ex_store).
- Stall signals: all four stall_* outputs are one common signal, stall.
- Reset (async, effective immediately):
  - state = IDLE.
  - Every output is 0, including mem_timeout and susp_cnt. da_req drops in the same cycle reset asserts.
- State IDLE:
  - If mem_op: da_req = 1 and stall = 1 (both combinational). Next state is WAIT.
  - Otherwise: da_req = 0 and stall = 0.
  - da_ack arriving in IDLE is ignored; the earliest legal ack is the cycle after the request is first seen.
- State WAIT:
  - da_req = 1 and stall = 1.
  - On da_ack, next state is DONE.
  - The wait counter increments each WAIT cycle without an ack.
  - When the wait counter reaches TIMEOUT_CYC-1, mem_timeout is set and stays set until reset. The block keeps waiting; there is no abort.
- State DONE (exactly one cycle):
  - suspend_finish = 1, stall = 0, da_req = 0.
  - The access instruction leaves EX at the end of this cycle. ID/EX captures the forwarded mem_wd here.
  - mem_op is NOT re-evaluated in DONE, so the same access cannot be re-issued.
  - Next state is IDLE.
- Back-to-back accesses: IDLE re-detects the next access the cycle after DONE. Minimum per-access occupancy is IDLE → WAIT(≥1) → DONE, i.e. 3 cycles.
- Flush:
  - flush_if_id = flush_id_ex = ex_valid & ex_jump & ~stall (combinational).
  - Flush is suppressed whenever stall = 1.
  - If ex_jump and mem_op occur together, mem_op wins and flush is 0.
- susp_cnt: increments on every cycle with stall = 1.
- The wait counter clears on entry to WAIT. It is internal and is ceil(log2(TIMEOUT_CYC)) bits wide.
- Reset asserted mid-WAIT: the outstanding request is abandoned. The memory side is required to tolerate a dropped da_req.

Test Plan:
- Reset: assert cpu_rst mid-sequence → all outputs 0 asynchronously. After release with mem_op=0, state stays IDLE and stall=0.
- Single load, ack 3 cycles after request:
  - stimulus: ex_valid=1, ex_sel_ram=1.
  - da_req and stall are 1 for 4 cycles (IDLE cycle + 3 WAIT cycles).
  - suspend_finish is 1 on exactly the next cycle, with stall=0.
  - susp_cnt = 4.
- Back-to-back load then store, each acked after 1 cycle → two separate requests of 2 cycles each, each followed by one suspend_finish pulse. No request is issued in either DONE cycle.
- Jump in IDLE (ex_jump=1, mem_op=0) → flush_if_id = flush_id_ex = 1 for that cycle only. Same jump presented during WAIT → flush stays 0.
- Timeout with TIMEOUT_CYC=8 and no ack:
  - mem_timeout rises after 7 WAIT cycles; da_req stays 1.
  - A later ack → normal DONE, mem_timeout remains 1.
- Counter wrap with CNT_W=4: 17 stalled cycles → susp_cnt = 1.
